// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: one wr_en request per byte, paced by
// the transmitter's tx_busy, with a no-acknowledge timeout and sticky error flags.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                   system_clk,
    input  logic                   reset,
    input  logic [7:0]             wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic                   timeout_err,
    input  logic                   clr_err,
    output logic [7:0]             uart_din,
    output logic                   uart_wr_en,
    input  logic                   uart_tx_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(BUSY_TIMEOUT);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       din_q, din_d;
    logic             wr_en_q, wr_en_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             tmo_set;
    logic             push;
    logic             pop;

    // Flags derive from the registered level only, so a push into an empty
    // FIFO is seen by the sequencer one cycle later.
    assign full        = (level_q == LVL_FULL);
    assign empty       = (level_q == '0);
    assign wr_ready    = !full;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign timeout_err = tmo_q;
    assign uart_din    = din_q;
    assign uart_wr_en  = wr_en_q;

    assign push = wr_valid && !full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        wr_en_d = wr_en_q;
        tmo_set = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop     = 1'b1;
                    din_d   = mem_q[rd_ptr_q];
                    wr_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (uart_tx_busy) begin
                    wr_en_d = 1'b0;
                    state_d = BUSY;
                end else if (cnt_q == CNT_LAST) begin
                    // Transmitter never acknowledged: drop the byte and move on.
                    wr_en_d = 1'b0;
                    tmo_set = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUSY: begin
                wr_en_d = 1'b0;
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                wr_en_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Setting a sticky flag wins over a clear in the same cycle.
        ovf_d = ovf_q;
        if (wr_valid && full) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        tmo_d = tmo_q;
        if (tmo_set) begin
            tmo_d = 1'b1;
        end else if (clr_err) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            din_q    <= 8'h00;
            wr_en_q  <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            wr_en_q  <= wr_en_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    always_ff @(posedge system_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a behavioural transmitter, a queue-based FIFO model
// and one task per scenario, ending in a single summary line.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DEPTH    = 16;
    localparam int BT       = 8;
    localparam int LVL_W    = $clog2(DEPTH) + 1;
    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_NEVER  = 2;

    logic             system_clk = 1'b0;
    logic             reset      = 1'b0;
    logic [7:0]       wr_data    = 8'h00;
    logic             wr_valid   = 1'b0;
    logic             wr_ready;
    logic [LVL_W-1:0] level;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             timeout_err;
    logic             clr_err    = 1'b0;
    logic [7:0]       uart_din;
    logic             uart_wr_en;
    logic             uart_tx_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    // Transmitter model state
    int         tx_mode   = M_NORMAL;
    int         tx_delay  = 3;
    int         tx_hold   = 100;
    bit         tx_rand   = 1'b0;
    bit         tx_active = 1'b0;
    int         tx_cnt    = 0;
    logic       tx_prev   = 1'b0;
    logic [7:0] rx_q[$];

    // FIFO reference model state
    logic [7:0]       exp_q[$];
    int               mdl_level = 0;
    bit               push_seen = 1'b0;
    logic [7:0]       push_byte = 8'h00;
    logic             mon_prev  = 1'b0;
    logic [LVL_W-1:0] exp_lvl;

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
        .system_clk  (system_clk),
        .reset       (reset),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clr_err     (clr_err),
        .uart_din    (uart_din),
        .uart_wr_en  (uart_wr_en),
        .uart_tx_busy(uart_tx_busy)
    );

    always #5 system_clk = ~system_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Transmitter: latches the byte on each new request, raises busy after
    // tx_delay cycles and holds it for tx_hold cycles.
    initial begin
        logic rise;
        forever begin
            @(negedge system_clk);
            rise    = uart_wr_en && !tx_prev;
            tx_prev = uart_wr_en;
            case (tx_mode)
                M_STALL: begin
                    uart_tx_busy = 1'b1;
                    tx_active    = 1'b0;
                end
                M_NEVER: begin
                    uart_tx_busy = 1'b0;
                    tx_active    = 1'b0;
                end
                default: begin
                    if (!tx_active) uart_tx_busy = 1'b0;
                    if (rise) begin
                        checks++;
                        if (tx_active) begin
                            errors++;
                            $display("FAIL overlap: new request %02h while transmitter busy=%0b active=1, required idle", uart_din, uart_tx_busy);
                        end else begin
                            rx_q.push_back(uart_din);
                            tx_active = 1'b1;
                            tx_cnt    = 0;
                            if (tx_rand) begin
                                tx_delay = $urandom_range(1, 3);
                                tx_hold  = $urandom_range(1, 6);
                            end
                        end
                    end
                    if (tx_active) begin
                        tx_cnt++;
                        if (tx_cnt == tx_delay) uart_tx_busy = 1'b1;
                        if (tx_cnt == tx_delay + tx_hold) begin
                            uart_tx_busy = 1'b0;
                            tx_active    = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Push acceptance is decided from the model's own occupancy.
    initial begin
        forever begin
            @(posedge system_clk);
            if (reset) begin
                push_seen = wr_valid && (mdl_level < DEPTH);
                push_byte = wr_data;
            end else begin
                push_seen = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge reset);
            exp_q.delete();
            mdl_level = 0;
            mon_prev  = 1'b0;
            push_seen = 1'b0;
        end
    end

    // Each new request is a pop of the model queue head.
    initial begin
        forever begin
            @(negedge system_clk);
            if (reset) begin
                if (push_seen) begin
                    exp_q.push_back(push_byte);
                    mdl_level++;
                    push_seen = 1'b0;
                end
                if (uart_wr_en && !mon_prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_order: request with din=%02h, required no request (model queue empty)", uart_din);
                    end else begin
                        if (uart_din !== exp_q[0]) begin
                            errors++;
                            $display("FAIL pop_order: din=%02h, required %02h", uart_din, exp_q[0]);
                        end
                        void'(exp_q.pop_front());
                    end
                    mdl_level--;
                end
                mon_prev = uart_wr_en;
                exp_lvl  = LVL_W'(mdl_level);
                checks++;
                if (level !== exp_lvl || level > DEPTH) begin
                    errors++;
                    $display("FAIL level: got %0d, required %0d", level, mdl_level);
                end
                checks++;
                if (empty !== (mdl_level == 0) || full !== (mdl_level == DEPTH) || wr_ready !== (mdl_level < DEPTH)) begin
                    errors++;
                    $display("FAIL status: empty=%0b full=%0b wr_ready=%0b, required level %0d", empty, full, wr_ready, mdl_level);
                end
            end
        end
    end

    task automatic push_one(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        @(negedge system_clk);
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge system_clk);
        clr_err = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int n = 0;
        while (!(empty && !uart_wr_en && !uart_tx_busy && !tx_active) && n < maxc) begin
            @(negedge system_clk);
            n++;
        end
        repeat (2) @(negedge system_clk);
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_drain: still active after %0d cycles, required idle", nm, n);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if (level !== 0)       begin errors++; $display("FAIL rst_level: got %0d, required 0", level); end
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL rst_empty: got %0b, required 1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL rst_full: got %0b, required 0", full); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %0b, required 1", wr_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %0b, required 0", overflow); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %0b, required 0", timeout_err); end
        checks++; if (uart_din !== 8'h00) begin errors++; $display("FAIL rst_din: got %02h, required 00", uart_din); end
        checks++; if (uart_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %0b, required 0", uart_wr_en); end
    endtask

    task automatic test_single();
        int n = 0;
        tx_mode = M_NORMAL; tx_rand = 1'b0; tx_delay = 3; tx_hold = 100;
        rx_q.delete();
        push_one(8'hA5);
        checks++;
        if (uart_wr_en !== 1'b0 || level !== 1) begin
            errors++; $display("FAIL single_after_push: wr_en=%0b level=%0d, required 0 and 1", uart_wr_en, level);
        end
        @(negedge system_clk);
        checks++;
        if (uart_wr_en !== 1'b1 || uart_din !== 8'hA5 || level !== 0) begin
            errors++; $display("FAIL single_request: wr_en=%0b din=%02h level=%0d, required 1 A5 0", uart_wr_en, uart_din, level);
        end
        while (uart_tx_busy !== 1'b1 && n < 10) begin
            @(negedge system_clk);
            n++;
        end
        @(negedge system_clk);
        checks++;
        if (uart_wr_en !== 1'b0) begin
            errors++; $display("FAIL single_wr_en_fall: got %0b one cycle after busy, required 0", uart_wr_en);
        end
        wait_drain(300, "single");
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            errors++; $display("FAIL single_rx: received %0d bytes, required one byte A5", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3];
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'hAA;
        tx_mode = M_NORMAL; tx_rand = 1'b0; tx_delay = 2; tx_hold = 6;
        rx_q.delete();
        for (int i = 0; i < 3; i++) begin
            wr_data  = bytes[i];
            wr_valid = 1'b1;
            @(negedge system_clk);
        end
        wr_valid = 1'b0;
        wait_drain(300, "b2b");
        checks++;
        if (rx_q.size() != 3) begin
            errors++; $display("FAIL b2b_count: received %0d bytes, required 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== bytes[i]) begin
                    errors++; $display("FAIL b2b_byte%0d: got %02h, required %02h", i, rx_q[i], bytes[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        tx_mode = M_STALL;
        rx_q.delete();
        repeat (2) @(negedge system_clk);
        for (int i = 0; i < DEPTH; i++) begin
            wr_data  = 8'(8'h10 + i);
            wr_valid = 1'b1;
            @(negedge system_clk);
        end
        wr_valid = 1'b0;
        checks++;
        if (full !== 1'b1 || wr_ready !== 1'b0 || level !== DEPTH || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_full: full=%0b wr_ready=%0b level=%0d overflow=%0b, required 1 0 %0d 0", full, wr_ready, level, overflow, DEPTH);
        end
        push_one(8'hEE);
        checks++;
        if (overflow !== 1'b1 || level !== DEPTH || wr_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_drop: overflow=%0b level=%0d wr_ready=%0b, required 1 %0d 0", overflow, level, wr_ready, DEPTH);
        end
        wr_valid = 1'b1; wr_data = 8'hEF;
        pulse_clr();
        wr_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set_priority: overflow=%0b after set and clear together, required 1", overflow);
        end
        pulse_clr();
        checks++;
        if (overflow !== 1'b0 || level !== DEPTH) begin
            errors++; $display("FAIL ovf_clear: overflow=%0b level=%0d, required 0 %0d", overflow, level, DEPTH);
        end
        tx_mode = M_NORMAL; tx_rand = 1'b0; tx_delay = 1; tx_hold = 2;
        wait_drain(2000, "ovf");
        checks++;
        if (rx_q.size() != DEPTH) begin
            errors++; $display("FAIL ovf_rx_count: received %0d bytes, required %0d", rx_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (rx_q[i] !== 8'(8'h10 + i)) begin
                    errors++; $display("FAIL ovf_rx%0d: got %02h, required %02h", i, rx_q[i], 8'(8'h10 + i));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n  = 0;
        int hi = 0;
        tx_mode = M_NEVER;
        @(negedge system_clk);
        wr_data = 8'h3C; wr_valid = 1'b1;
        @(negedge system_clk);
        wr_data = 8'h7E;
        @(negedge system_clk);
        wr_valid = 1'b0;
        while (uart_wr_en !== 1'b1 && n < 20) begin
            @(negedge system_clk);
            n++;
        end
        while (uart_wr_en === 1'b1 && hi < BT + 10) begin
            hi++;
            @(negedge system_clk);
        end
        checks++;
        if (hi != BT) begin
            errors++; $display("FAIL tmo_length: wr_en high %0d cycles, required %0d", hi, BT);
        end
        checks++;
        if (timeout_err !== 1'b1 || uart_wr_en !== 1'b0) begin
            errors++; $display("FAIL tmo_flag: timeout_err=%0b wr_en=%0b, required 1 0", timeout_err, uart_wr_en);
        end
        @(negedge system_clk);
        checks++;
        if (uart_wr_en !== 1'b1 || uart_din !== 8'h7E) begin
            errors++; $display("FAIL tmo_next_req: wr_en=%0b din=%02h, required 1 7E", uart_wr_en, uart_din);
        end
        wait_drain(200, "tmo");
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL tmo_sticky: got %0b, required 1", timeout_err);
        end
        pulse_clr();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL tmo_clear: got %0b, required 0", timeout_err);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent[$];
        logic [7:0] b;
        int g;
        int n;
        tx_mode = M_NORMAL; tx_rand = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 20; i++) begin
            g = $urandom_range(0, 3);
            repeat (g) @(negedge system_clk);
            n = 0;
            while (full && n < 500) begin
                @(negedge system_clk);
                n++;
            end
            b = 8'($urandom);
            sent.push_back(b);
            push_one(b);
        end
        wait_drain(3000, "wrap");
        tx_rand = 1'b0;
        checks++;
        if (rx_q.size() != sent.size()) begin
            errors++; $display("FAIL wrap_count: received %0d bytes, required %0d", rx_q.size(), sent.size());
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                checks++;
                if (rx_q[i] !== sent[i]) begin
                    errors++; $display("FAIL wrap_byte%0d: got %02h, required %02h", i, rx_q[i], sent[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n    = 0;
        int hits = 0;
        tx_mode = M_NEVER;
        @(negedge system_clk);
        for (int i = 0; i < 6; i++) begin
            wr_data  = 8'(8'h60 + i);
            wr_valid = 1'b1;
            @(negedge system_clk);
        end
        wr_valid = 1'b0;
        checks++;
        if (uart_wr_en !== 1'b1 || level !== 5) begin
            errors++; $display("FAIL rmid_setup: wr_en=%0b level=%0d, required 1 5", uart_wr_en, level);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (uart_wr_en !== 1'b0) begin
            errors++; $display("FAIL rmid_wr_en: got %0b during reset, required 0", uart_wr_en);
        end
        checks++;
        if (level !== 0 || empty !== 1'b1) begin
            errors++; $display("FAIL rmid_fifo: level=%0d empty=%0b during reset, required 0 1", level, empty);
        end
        @(posedge system_clk);
        #2 reset = 1'b1;
        repeat (20) begin
            @(negedge system_clk);
            if (uart_wr_en !== 1'b0) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++; $display("FAIL rmid_quiet: wr_en high %0d cycles after reset, required 0", hits);
        end
        push_one(8'h42);
        while (uart_wr_en !== 1'b1 && n < 10) begin
            @(negedge system_clk);
            n++;
        end
        checks++;
        if (uart_wr_en !== 1'b1 || uart_din !== 8'h42) begin
            errors++; $display("FAIL rmid_new_push: wr_en=%0b din=%02h, required 1 42", uart_wr_en, uart_din);
        end
        wait_drain(200, "rmid");
        pulse_clr();
    endtask

    initial begin
        repeat (2) @(negedge system_clk);
        test_reset();
        @(posedge system_clk);
        #2 reset = 1'b1;
        @(negedge system_clk);
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
